// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the decode-to-execute pipeline register slice.
//   - default widths for data, register address and ALU opcode
//   - width of the hazard bubble counter
//   - FSM state encoding used by id_ex_stage
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int OP_W_DEF   = 4;
    localparam int CNT_W      = 16;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode-side inputs, control inputs (hold/flush) and the
// execute-side outputs of id_ex_stage.
//   master : the surroundings (decode, hazard control, observers of ex_*)
//   slave  : the id_ex_stage register itself
// ---------------------------------------------------------------------------
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF
);

    // Decode side
    logic              id_valid;
    logic [ADDR_W-1:0] id_wr_add;
    logic [ADDR_W-1:0] id_wr_add2;
    logic              id_uses_dst;
    logic              id_uses_src;
    logic [DATA_W-1:0] id_read_data1;
    logic [DATA_W-1:0] id_read_data2;
    logic              id_wb;
    logic              id_mem_read;
    logic              id_mem_write;
    logic [OP_W-1:0]   id_alu_op;

    // Pipeline control
    logic              hold;
    logic              flush;

    // Execute side
    logic              ex_valid;
    logic              ex_wb;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [ADDR_W-1:0] ex_wr_add;
    logic [ADDR_W-1:0] ex_wr_add2;
    logic [DATA_W-1:0] ex_read_data1;
    logic [DATA_W-1:0] ex_read_data2;
    logic [OP_W-1:0]   ex_alu_op;
    logic              stall;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_valid, id_wr_add, id_wr_add2, id_uses_dst, id_uses_src,
               id_read_data1, id_read_data2, id_wb, id_mem_read, id_mem_write,
               id_alu_op, hold, flush,
        input  ex_valid, ex_wb, ex_mem_read, ex_mem_write, ex_wr_add,
               ex_wr_add2, ex_read_data1, ex_read_data2, ex_alu_op, stall,
               bubble_count
    );

    modport slave (
        input  id_valid, id_wr_add, id_wr_add2, id_uses_dst, id_uses_src,
               id_read_data1, id_read_data2, id_wb, id_mem_read, id_mem_write,
               id_alu_op, hold, flush,
        output ex_valid, ex_wb, ex_mem_read, ex_mem_write, ex_wr_add,
               ex_wr_add2, ex_read_data1, ex_read_data2, ex_alu_op, stall,
               bubble_count
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard compare. Flags the case where the
// instruction in execute is a register-writing load and the instruction in
// decode reads that same register as an operand.
// Ports:
//   ex_valid, ex_mem_read, ex_wb, ex_wr_add : instruction currently in execute
//   id_valid, id_uses_src, id_wr_add2        : decode source operand
//   id_uses_dst, id_wr_add                   : decode destination-as-operand
//   hazard                                   : a bubble is required
// ---------------------------------------------------------------------------
module load_use_detect
    import id_ex_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_wb,
    input  logic [ADDR_W-1:0] ex_wr_add,
    input  logic              id_valid,
    input  logic              id_uses_src,
    input  logic [ADDR_W-1:0] id_wr_add2,
    input  logic              id_uses_dst,
    input  logic [ADDR_W-1:0] id_wr_add,
    output logic              hazard
);

    logic ex_is_load;
    logic src_match;
    logic dst_match;

    assign ex_is_load = ex_valid & ex_mem_read & ex_wb;
    assign src_match  = id_uses_src & (id_wr_add2 == ex_wr_add);
    assign dst_match  = id_uses_dst & (id_wr_add  == ex_wr_add);
    assign hazard     = ex_is_load & id_valid & (src_match | dst_match);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Decode-to-execute pipeline register with load-use hazard bubble insertion.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : id_ex_stage_if.slave -- decode fields in, hold/flush in,
//          registered ex_* fields out, combinational stall out,
//          saturating bubble_count out
// Per-edge priority: rst > hold > flush/pending flush > hazard > normal load.
// A hold that coincides with a flush remembers the flush so the squash still
// happens on the first edge after the hold lifts.
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    // ---- execute-side registers (stage p1) ----
    logic              vld_p1;
    logic              wb_p1;
    logic              mem_read_p1;
    logic              mem_write_p1;
    logic [ADDR_W-1:0] wr_add_p1;
    logic [ADDR_W-1:0] wr_add2_p1;
    logic signed [DATA_W-1:0] rd1_p1;
    logic signed [DATA_W-1:0] rd2_p1;
    logic [OP_W-1:0]   alu_op_p1;

    logic              vld_d;
    logic              wb_d;
    logic              mem_read_d;
    logic              mem_write_d;
    logic [ADDR_W-1:0] wr_add_d;
    logic [ADDR_W-1:0] wr_add2_d;
    logic signed [DATA_W-1:0] rd1_d;
    logic signed [DATA_W-1:0] rd2_d;
    logic [OP_W-1:0]   alu_op_d;

    state_t            state_q;
    state_t            state_d;
    logic              flush_pend_q;
    logic              flush_pend_d;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_d;

    logic              hazard;
    logic              flush_any;
    logic              take_hazard;

    load_use_detect #(
        .ADDR_W (ADDR_W)
    ) u_detect (
        .ex_valid    (vld_p1),
        .ex_mem_read (mem_read_p1),
        .ex_wb       (wb_p1),
        .ex_wr_add   (wr_add_p1),
        .id_valid    (bus.id_valid),
        .id_uses_src (bus.id_uses_src),
        .id_wr_add2  (bus.id_wr_add2),
        .id_uses_dst (bus.id_uses_dst),
        .id_wr_add   (bus.id_wr_add),
        .hazard      (hazard)
    );

    assign flush_any   = bus.flush | flush_pend_q;
    // In BUBBLE the compare is ignored so one hazard yields exactly one bubble.
    assign take_hazard = (state_q == RUN) & hazard;

    assign bus.stall = bus.hold | (take_hazard & ~flush_any);

    always_comb begin
        vld_d        = vld_p1;
        wb_d         = wb_p1;
        mem_read_d   = mem_read_p1;
        mem_write_d  = mem_write_p1;
        wr_add_d     = wr_add_p1;
        wr_add2_d    = wr_add2_p1;
        rd1_d        = rd1_p1;
        rd2_d        = rd2_p1;
        alu_op_d     = alu_op_p1;
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        bubble_cnt_d = bubble_cnt_q;

        if (bus.hold) begin
            flush_pend_d = flush_pend_q | bus.flush;
        end else if (flush_any | take_hazard) begin
            // Bubble: control cleared, datapath zeroed for clean waveforms.
            vld_d        = 1'b0;
            wb_d         = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            wr_add_d     = '0;
            wr_add2_d    = '0;
            rd1_d        = '0;
            rd2_d        = '0;
            alu_op_d     = '0;
            flush_pend_d = 1'b0;
            if (flush_any) begin
                state_d = RUN;
            end else begin
                state_d      = BUBBLE;
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end
        end else begin
            // An invalid decode slot must never write or touch memory.
            vld_d       = bus.id_valid;
            wb_d        = bus.id_valid & bus.id_wb;
            mem_read_d  = bus.id_valid & bus.id_mem_read;
            mem_write_d = bus.id_valid & bus.id_mem_write;
            wr_add_d    = bus.id_wr_add;
            wr_add2_d   = bus.id_wr_add2;
            rd1_d       = bus.id_read_data1;
            rd2_d       = bus.id_read_data2;
            alu_op_d    = bus.id_alu_op;
            state_d     = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1       <= 1'b0;
            wb_p1        <= 1'b0;
            mem_read_p1  <= 1'b0;
            mem_write_p1 <= 1'b0;
            wr_add_p1    <= '0;
            wr_add2_p1   <= '0;
            rd1_p1       <= '0;
            rd2_p1       <= '0;
            alu_op_p1    <= '0;
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            bubble_cnt_q <= '0;
        end else begin
            vld_p1       <= vld_d;
            wb_p1        <= wb_d;
            mem_read_p1  <= mem_read_d;
            mem_write_p1 <= mem_write_d;
            wr_add_p1    <= wr_add_d;
            wr_add2_p1   <= wr_add2_d;
            rd1_p1       <= rd1_d;
            rd2_p1       <= rd2_d;
            alu_op_p1    <= alu_op_d;
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid      = vld_p1;
    assign bus.ex_wb         = wb_p1;
    assign bus.ex_mem_read   = mem_read_p1;
    assign bus.ex_mem_write  = mem_write_p1;
    assign bus.ex_wr_add     = wr_add_p1;
    assign bus.ex_wr_add2    = wr_add2_p1;
    assign bus.ex_read_data1 = rd1_p1;
    assign bus.ex_read_data2 = rd2_p1;
    assign bus.ex_alu_op     = alu_op_p1;
    assign bus.bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: pass-through, load-use bubble, independent
// load, hold with flush, flush-over-hazard, reset in BUBBLE, counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    id_ex_stage_if b ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] wa, input logic [2:0] wa2,
                          input logic ud, input logic us, input logic [15:0] d1,
                          input logic [15:0] d2, input logic wb, input logic mr,
                          input logic mw, input logic [3:0] op);
        b.id_valid      = v;
        b.id_wr_add     = wa;
        b.id_wr_add2    = wa2;
        b.id_uses_dst   = ud;
        b.id_uses_src   = us;
        b.id_read_data1 = d1;
        b.id_read_data2 = d2;
        b.id_wb         = wb;
        b.id_mem_read   = mr;
        b.id_mem_write  = mw;
        b.id_alu_op     = op;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        b.hold  = 1'b0;
        b.flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 4'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ex_valid", {31'b0, b.ex_valid}, 32'h0);
        chk("rst_ex_wb", {31'b0, b.ex_wb}, 32'h0);
        chk("rst_ex_rd1", {16'b0, b.ex_read_data1}, 32'h0);
        chk("rst_bubble_count", {16'b0, b.bubble_count}, 32'h0);
        chk("rst_stall", {31'b0, b.stall}, 32'h0);

        // No hazard: ADD writing r2, then consumer of r2
        set_id(1, 3'd2, 3'd1, 1, 1, 16'h1111, 16'h2222, 1, 0, 0, 4'h3);
        tick();
        chk("add_ex_wr_add", {29'b0, b.ex_wr_add}, 32'd2);
        chk("add_ex_wb", {31'b0, b.ex_wb}, 32'h1);
        set_id(1, 3'd3, 3'd2, 1, 1, 16'h1234, 16'h5555, 1, 0, 0, 4'h1);
        #1;
        chk("nohaz_stall", {31'b0, b.stall}, 32'h0);
        tick();
        chk("nohaz_ex_rd1", {16'b0, b.ex_read_data1}, 32'h1234);
        chk("nohaz_ex_wr_add2", {29'b0, b.ex_wr_add2}, 32'd2);

        // Load-use: LDM r4 then consumer of r4
        set_id(1, 3'd4, 3'd0, 0, 1, 16'h0, 16'h0, 1, 1, 0, 4'h0);
        tick();
        chk("ldm_ex_mem_read", {31'b0, b.ex_mem_read}, 32'h1);
        set_id(1, 3'd5, 3'd4, 1, 1, 16'hAAAA, 16'hBBBB, 1, 0, 0, 4'h2);
        #1;
        chk("lu_stall", {31'b0, b.stall}, 32'h1);
        tick();
        chk("lu_bubble_valid", {31'b0, b.ex_valid}, 32'h0);
        chk("lu_bubble_wb", {31'b0, b.ex_wb}, 32'h0);
        chk("lu_bubble_count", {16'b0, b.bubble_count}, 32'h1);
        chk("lu_stall_released", {31'b0, b.stall}, 32'h0);
        tick();
        chk("lu_reload_valid", {31'b0, b.ex_valid}, 32'h1);
        chk("lu_reload_rd1", {16'b0, b.ex_read_data1}, 32'hAAAA);
        chk("lu_reload_wr_add", {29'b0, b.ex_wr_add}, 32'd5);

        // Load with no dependency
        set_id(1, 3'd4, 3'd1, 0, 1, 16'h0, 16'h0, 1, 1, 0, 4'h0);
        tick();
        set_id(1, 3'd5, 3'd6, 1, 1, 16'h5656, 16'h6565, 1, 0, 0, 4'h5);
        #1;
        chk("nodep_stall", {31'b0, b.stall}, 32'h0);
        tick();
        chk("nodep_valid", {31'b0, b.ex_valid}, 32'h1);
        chk("nodep_rd1", {16'b0, b.ex_read_data1}, 32'h5656);
        chk("nodep_count", {16'b0, b.bubble_count}, 32'h1);

        // Hold for 3 cycles with flush in cycle 2
        b.hold = 1'b1;
        set_id(1, 3'd7, 3'd0, 1, 0, 16'h7777, 16'h0, 1, 0, 0, 4'h6);
        #1;
        chk("hold1_stall", {31'b0, b.stall}, 32'h1);
        tick();
        chk("hold1_wr_add", {29'b0, b.ex_wr_add}, 32'd5);
        chk("hold1_rd1", {16'b0, b.ex_read_data1}, 32'h5656);
        b.flush = 1'b1;
        #1;
        chk("hold2_stall", {31'b0, b.stall}, 32'h1);
        tick();
        chk("hold2_valid", {31'b0, b.ex_valid}, 32'h1);
        chk("hold2_alu_op", {28'b0, b.ex_alu_op}, 32'h5);
        b.flush = 1'b0;
        #1;
        chk("hold3_stall", {31'b0, b.stall}, 32'h1);
        tick();
        chk("hold3_wr_add", {29'b0, b.ex_wr_add}, 32'd5);
        b.hold = 1'b0;
        #1;
        chk("posthold_stall", {31'b0, b.stall}, 32'h0);
        tick();
        chk("posthold_bubble", {31'b0, b.ex_valid}, 32'h0);
        tick();
        chk("posthold_load_valid", {31'b0, b.ex_valid}, 32'h1);
        chk("posthold_load_rd1", {16'b0, b.ex_read_data1}, 32'h7777);

        // Flush beats hazard
        set_id(1, 3'd4, 3'd1, 0, 1, 16'h0, 16'h0, 1, 1, 0, 4'h0);
        tick();
        set_id(1, 3'd5, 3'd4, 0, 1, 16'h4444, 16'h0, 1, 0, 0, 4'h2);
        b.flush = 1'b1;
        #1;
        chk("fbh_stall", {31'b0, b.stall}, 32'h0);
        tick();
        chk("fbh_valid", {31'b0, b.ex_valid}, 32'h0);
        chk("fbh_count", {16'b0, b.bubble_count}, 32'h1);
        b.flush = 1'b0;

        // Reset in BUBBLE
        set_id(1, 3'd4, 3'd1, 0, 1, 16'h0, 16'h0, 1, 1, 0, 4'h0);
        tick();
        set_id(1, 3'd5, 3'd4, 0, 1, 16'h4444, 16'h0, 1, 0, 0, 4'h2);
        tick();
        chk("prerst_count", {16'b0, b.bubble_count}, 32'h2);
        chk("prerst_state", {31'b0, dut.state_q}, {31'b0, BUBBLE});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", {31'b0, b.ex_valid}, 32'h0);
        chk("midrst_mem_read", {31'b0, b.ex_mem_read}, 32'h0);
        chk("midrst_wr_add", {29'b0, b.ex_wr_add}, 32'h0);
        chk("midrst_count", {16'b0, b.bubble_count}, 32'h0);
        chk("midrst_state", {31'b0, dut.state_q}, {31'b0, RUN});
        chk("midrst_stall", {31'b0, b.stall}, 32'h0);

        // Saturation: counter preset near the top, then self-dependent loads
        set_id(1, 3'd4, 3'd4, 0, 1, 16'h0, 16'h0, 1, 1, 0, 4'h0);
        force dut.bubble_cnt_q = 16'hFFFD;
        #1;
        release dut.bubble_cnt_q;
        tick();
        chk("sat_preload", {16'b0, b.bubble_count}, 32'hFFFD);
        tick();
        chk("sat_fffe", {16'b0, b.bubble_count}, 32'hFFFE);
        tick();
        tick();
        chk("sat_ffff", {16'b0, b.bubble_count}, 32'hFFFF);
        tick();
        tick();
        chk("sat_hold_ffff", {16'b0, b.bubble_count}, 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
